mem_sram_ctrl: RTL and testbench
================================

# mem_sram_ctrl

Multi-cycle controller that sequences every MEM-stage data access onto the off-chip 16-bit SRAM and freezes the pipeline until the access completes. It sits between the MEM stage and the MEM/WB pipeline register. It splits each 32-bit load or store into two half-word SRAM cycles with programmable wait states. It drives `ready`, which the pipeline uses as `freeze = ~ready`.

## Interface
- `WAIT_CYCLES`, 2: cycles per half-word phase; legal minimum is 2.
- `BASE_ADDR`, 1024: data-memory base subtracted from the CPU address.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `rd_en`  in  1  load request from the MEM stage.
- `wr_en`  in  1  store request from the MEM stage.
- `address`  in  32  CPU byte address.
- `write_data`  in  32  store data.
- `read_data`  out  32  load data; held until the next load completes.
- `ready`  out  1  pipeline may advance this cycle.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq_o`  out  16  SRAM write data.
- `sram_dq_oe`  out  1  drive enable for the SRAM data bus.
- `sram_dq_i`  in  16  SRAM read data.
- `sram_we_n`  out  1  SRAM write strobe, active-low.

## Operation
- **States:** IDLE, LO, HI, DONE.
- **IDLE:**
  - When `rd_en|wr_en` is high, latch `address`, `write_data` and the operation, then go to LO.
  - If both `rd_en` and `wr_en` are high, the access is a write.
- **Address mapping:**
  - `eff = address - BASE_ADDR`; word index is `eff[18:2]`.
  - LO drives `sram_addr = {idx,1'b0}`; HI drives `{idx,1'b1}`.
  - `eff[1:0]` is ignored.
- **LO and HI:** each lasts exactly `WAIT_CYCLES` cycles, timed by the wait counter. LO then HI; HI then DONE.
- **Writes:**
  - `sram_dq_oe=1` throughout LO and HI.
  - `sram_dq_o` is `write_data[15:0]` in LO and `[31:16]` in HI.
  - `sram_we_n=0` for phase cycles 1..`WAIT_CYCLES`-1; `sram_we_n=1` on the last cycle of each phase.
  - Address and data are stable across the whole phase.
- **Reads:**
  - `sram_dq_oe=0` and `sram_we_n=1`.
  - `sram_dq_i` is captured into `read_data[15:0]` on the last LO cycle and into `read_data[31:16]` on the last HI cycle.
- **DONE:** lasts one cycle, then returns to IDLE unconditionally. The still-asserted request of the retiring instruction is not restarted.
- **ready:** `(state==IDLE && !(rd_en|wr_en)) || state==DONE`.
- **IDLE outputs:** `sram_addr=0`, `sram_dq_o=0`, `sram_dq_oe=0`, `sram_we_n=1`.
- **Reset values** (`rst` low, any state): state IDLE, counter 0, `read_data=0`, `sram_we_n=1`, `sram_dq_oe=0`, `sram_addr=0`, `sram_dq_o=0`. `ready` is 1 if no request is present.
- **Reset mid-access:** aborts immediately. Any partial write is left in the SRAM; no completion is signalled.

## Timing
- **Access latency:** the request cycle plus `2*WAIT_CYCLES` phase cycles, then DONE. `ready` is low for `2*WAIT_CYCLES+1` cycles and high in DONE. For W=2 that is 5 low cycles, with DONE on the 6th.
- **Back-to-back accesses:** the next instruction's request is seen in IDLE the cycle after DONE.
- **Register placement:**
  - All SRAM outputs decode combinationally from state, counter and the latched request.
  - `read_data` and state are registered.

## Configuration
- **Macro:** `MEM_SRAM_CTRL_POSTED_WRITE_EN`.
- **Defined:**
  - A write accepted in IDLE with no access in flight returns `ready=1` in the request cycle.
  - The write drains in the background through LO and HI, then HI goes straight to IDLE with no DONE.
  - Any request arriving while draining sees `ready=0` until the FSM returns to IDLE and services it.
  - Reads are unchanged.
- **Undefined:** writes stall exactly like reads.

## Structure
- **Package `mem_sram_ctrl_pkg`:**
  - state enum (IDLE, LO, HI, DONE)
  - `SRAM_ADDR_W=18`
  - `SRAM_DATA_W=16`
  - default `WAIT_CYCLES` and `BASE_ADDR`
- **Sub-module `sram_wait_cnt`:** a load/clear down-counter that flags the first and last cycle of a phase.

## Test plan
All scenarios use W=2.
- **Read:** `rd_en`, `address=1032`, SRAM model word at half-word 4 = `16'h5678`, half-word 5 = `16'h1234`. Expect `sram_addr` 4, 4, 5, 5; `ready` low 5 cycles; `read_data=32'h12345678` in DONE.
- **Write:** `wr_en`, `address=1024`, `write_data=32'hDEADBEEF`. Expect half-word 0 = `BEEF` and half-word 1 = `DEAD`; `sram_we_n` pattern 0,1,0,1; `sram_dq_oe` high for 4 cycles.
- **Simultaneous request:** `rd_en=wr_en=1` → treated as a write; `read_data` unchanged.
- **Reset mid-access:** assert `rst` low in the second HI cycle. Expect `sram_we_n=1`, `sram_dq_oe=0`, state IDLE the same cycle; `read_data=0`.
- **Back-to-back:** write then read of the same address. The read returns the written value; `ready` pulses high for exactly one cycle between the two accesses.
- **With `MEM_SRAM_CTRL_POSTED_WRITE_EN`:** a write followed immediately by a read. The write shows `ready=1` in its request cycle; the read stalls 4 extra cycles and returns the new data.

Source files
------------

// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Optional feature macro: MEM_SRAM_CTRL_POSTED_WRITE_EN (see mem_sram_ctrl.sv).
package mem_sram_ctrl_pkg;

    // Access sequencer states: idle, low half-word phase, high half-word phase, completion.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    // One 32-bit word spans two half-words, so the word index is one bit narrower.
    localparam int WORD_IDX_W = SRAM_ADDR_W - 1;

    localparam int          DEF_WAIT_CYCLES = 2;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;

endpackage

// File: rtl/mem_sram_wait_cnt.sv
// Phase timer: a load/clear down-counter that marks the first and the last
// cycle of a WAIT_CYCLES-long SRAM phase. Load on phase entry; it then counts
// down to zero and holds there.
module sram_wait_cnt #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clr,
    output logic first,
    output logic last
);

    localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over load; otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign first = (cnt_q == LOAD_VAL);
    assign last  = (cnt_q == '0);

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage SRAM controller: splits each 32-bit load/store into two 16-bit
// SRAM phases (low half-word, then high half-word) and holds ready low until
// the access retires. SRAM pins decode combinationally from state, phase
// timer and the latched request; state and read_data are registered.
// Optional feature macro: MEM_SRAM_CTRL_POSTED_WRITE_EN -- when defined, a
// write accepted in IDLE releases the pipeline immediately and drains in the
// background, returning from HI straight to IDLE.
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_o,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_i,
    output logic                   sram_we_n
);

    state_e                state_q, state_d;
    logic                  is_wr_q, is_wr_d;
    logic [WORD_IDX_W-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           read_data_q, read_data_d;

    logic        req;
    logic [31:0] eff;
    logic        unused_eff_bits;
    logic        cnt_load, cnt_clr;
    logic        ph_first, ph_last;
    logic        in_phase, hi_phase;

    assign req = rd_en | wr_en;

    // Byte offset inside the word and bits above the 512 KiB window are dropped.
    assign eff             = address - BASE_ADDR;
    assign unused_eff_bits = ^{eff[31:19], eff[1:0]};

    sram_wait_cnt #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .clr  (cnt_clr),
        .first(ph_first),
        .last (ph_last)
    );

    // Next-state logic: latch the request in IDLE, step LO -> HI -> DONE on phase end.
    always_comb begin
        state_d  = state_q;
        is_wr_d  = is_wr_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        cnt_load = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    // A simultaneous read and write request is a write.
                    state_d  = ST_LO;
                    is_wr_d  = wr_en;
                    idx_d    = eff[18:2];
                    wdata_d  = write_data;
                    cnt_load = 1'b1;
                end
            end
            ST_LO: begin
                if (ph_last) begin
                    state_d  = ST_HI;
                    cnt_load = 1'b1;
                end
            end
            ST_HI: begin
                if (ph_last) begin
`ifdef MEM_SRAM_CTRL_POSTED_WRITE_EN
                    // Posted writes already released the pipeline; skip DONE.
                    state_d = is_wr_q ? ST_IDLE : ST_DONE;
`else
                    state_d = ST_DONE;
`endif
                    cnt_clr = 1'b1;
                end
            end
            ST_DONE: begin
                // The retiring instruction still holds its request; do not restart it.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read capture: sample the SRAM bus on the last cycle of each read phase.
    always_comb begin
        read_data_d = read_data_q;
        if (!is_wr_q && ph_last) begin
            if (state_q == ST_LO) begin
                read_data_d[15:0] = sram_dq_i;
            end else if (state_q == ST_HI) begin
                read_data_d[31:16] = sram_dq_i;
            end
        end
    end

    // State, latched request and load data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            is_wr_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
        end
    end

    // SRAM pin decode: address/data held steady for a whole phase, strobe
    // opens on the first phase cycle and releases on the last one.
    always_comb begin
        in_phase   = (state_q == ST_LO) || (state_q == ST_HI);
        hi_phase   = (state_q == ST_HI);
        sram_addr  = in_phase ? {idx_q, hi_phase} : '0;
        sram_dq_oe = in_phase && is_wr_q;
        sram_dq_o  = '0;
        if (sram_dq_oe) begin
            sram_dq_o = hi_phase ? wdata_q[31:16] : wdata_q[15:0];
        end
        sram_we_n  = !(sram_dq_oe && (ph_first || !ph_last));
    end

    // Pipeline release.
    always_comb begin
`ifdef MEM_SRAM_CTRL_POSTED_WRITE_EN
        // Writes retire on acceptance; while one drains, only a new request stalls.
        ready = ((state_q == ST_IDLE) && (!req || wr_en)) ||
                (state_q == ST_DONE) ||
                (in_phase && is_wr_q && !req);
`else
        ready = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
`endif
    end

    assign read_data = read_data_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: reset values, directed pin-level
// sequences, a vector table of back-to-back accesses, an abort by reset and
// randomized traffic checked against a word-level memory model.
module tb_mem_sram_ctrl;

    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'd1024;
`ifdef MEM_SRAM_CTRL_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk, rst, rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready, sram_dq_oe, sram_we_n;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;

    mem_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n)
    );

    // Off-chip SRAM: asynchronous read, write while the strobe is low.
    logic [15:0] mem [0:262143];
    assign sram_dq_i = mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: 32-bit words keyed by word index, plus pipeline-visible state.
    logic [31:0] wmodel [int];
    logic [31:0] last_rd;
    int          drain;

    function automatic logic [15:0] pat(int i);
        return 16'(i * 40503 + 7);
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'(((a - BASE) >> 2) & 32'h1FFFF);
    endfunction

    function automatic logic [31:0] mword(int idx);
        if (wmodel.exists(idx)) return wmodel[idx];
        return {pat(2 * idx + 1), pat(2 * idx)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One access held until the pipeline is released; checks stall length and load data.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_rd, input string nm);
        int exp_low;
        int lows;
        exp_low = drain + ((POSTED && wr) ? 0 : 2 * W + 1);
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        lows = 0;
        forever begin
            @(negedge clk);
            if (ready) break;
            lows++;
            if (lows > 100) break;
        end
        chk({nm, "_stall"}, lows, exp_low);
        chk({nm, "_rdata"}, read_data, exp_rd);
        if (wr) begin
            wmodel[widx(a)] = d;
            drain = POSTED ? 2 * W : 0;
        end else begin
            last_rd = exp_rd;
            drain = 0;
        end
    endtask

    // No request for n cycles: the pipeline must never be frozen.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rd_en = 1'b0; wr_en = 1'b0;
            @(negedge clk);
            chk("idle_ready", ready, 1);
            if (drain > 0) drain--;
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tv [7];

    logic [17:0] ra [4];
    logic [15:0] wd [4];
    logic        wn [4];

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = pat(i);
        mem[4] = 16'h5678;
        mem[5] = 16'h1234;
        wmodel[2] = 32'h12345678;
        last_rd = '0;
        drain = 0;

        // Reset state.
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        #2;
        chk("rst_ready", ready, 1);
        chk("rst_rdata", read_data, 0);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe", sram_dq_oe, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dq_o", sram_dq_o, 0);
        rd_en = 1'b1;
        #1;
        chk("rst_ready_req", ready, 0);
        rd_en = 1'b0;
        #9 rst = 1'b1;

        // Directed read at 1032: half-words 4,4,5,5, five stall cycles, then data.
        ra = '{18'd4, 18'd4, 18'd5, 18'd5};
        @(posedge clk); #1;
        rd_en = 1'b1; address = 32'd1032;
        @(negedge clk);
        chk("rd_c0_ready", ready, 0);
        chk("rd_c0_addr", sram_addr, 0);
        @(posedge clk); #1;
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(posedge clk);
            @(negedge clk);
            chk($sformatf("rd_addr%0d", i), sram_addr, ra[i]);
            chk($sformatf("rd_we_n%0d", i), sram_we_n, 1);
            chk($sformatf("rd_oe%0d", i), sram_dq_oe, 0);
            chk($sformatf("rd_ready%0d", i), ready, 0);
        end
        @(posedge clk); @(negedge clk);
        chk("rd_done_ready", ready, 1);
        chk("rd_done_data", read_data, 32'h12345678);
        last_rd = 32'h12345678;
        idle(2);

        // Directed write of DEADBEEF at 1024.
        ra = '{18'd0, 18'd0, 18'd1, 18'd1};
        wd = '{16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD};
        wn = '{1'b0, 1'b1, 1'b0, 1'b1};
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1024; write_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_c0_oe", sram_dq_oe, 0);
        @(posedge clk); #1;
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(posedge clk);
            @(negedge clk);
            chk($sformatf("wr_addr%0d", i), sram_addr, ra[i]);
            chk($sformatf("wr_dq%0d", i), sram_dq_o, wd[i]);
            chk($sformatf("wr_we_n%0d", i), sram_we_n, wn[i]);
            chk($sformatf("wr_oe%0d", i), sram_dq_oe, 1);
        end
        idle(4);
        chk("wr_mem_lo", mem[0], 16'hBEEF);
        chk("wr_mem_hi", mem[1], 16'hDEAD);
        chk("wr_rdata_kept", read_data, 32'h12345678);
        wmodel[0] = 32'hDEADBEEF;
        drain = 0;

        // Back-to-back vector table.
        tv[0] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF};
        tv[1] = '{1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 32'hDEADBEEF};
        tv[2] = '{1'b1, 1'b0, 32'd1040, 32'h0,        32'hCAFEF00D};
        tv[3] = '{1'b0, 1'b1, 32'd1027, 32'h0BADC0DE, 32'hCAFEF00D};
        tv[4] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h0BADC0DE};
        tv[5] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h12345678};
        tv[6] = '{1'b1, 1'b0, 32'd1042, 32'h0,        32'hCAFEF00D};
        for (int i = 0; i < 7; i++) begin
            do_access(tv[i].rd, tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].exp_rd,
                      $sformatf("vec%0d", i));
        end
        idle(2);

        // Reset in the second HI cycle of a write: bus released at once, load data cleared.
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1048; write_data = 32'h11223344;
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pre_oe", sram_dq_oe, 1);
        chk("abort_pre_addr", sram_addr, 18'd13);
        rst = 1'b0;
        #1;
        chk("abort_we_n", sram_we_n, 1);
        chk("abort_oe", sram_dq_oe, 0);
        chk("abort_addr", sram_addr, 0);
        chk("abort_rdata", read_data, 0);
        chk("abort_ready", ready, 1);
        @(negedge clk);
        rst = 1'b1;
        wmodel[widx(32'd1048)] = 32'h11223344;
        last_rd = '0;
        drain = 0;
        idle(2);
        do_access(1'b1, 1'b0, 32'd1048, 32'h0, 32'h11223344, "abort_readback");

        // Randomized traffic against the word model.
        for (int n = 0; n < 40; n++) begin
            int          op;
            logic [31:0] a, d, e;
            idle($urandom_range(0, 2));
            op = $urandom_range(0, 2);
            a  = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            d  = $urandom;
            e  = (op == 0) ? mword(widx(a)) : last_rd;
            do_access(op != 1, op != 0, a, d, e, $sformatf("rnd%0d", n));
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
